ysyx_22040228_clint: RTL

Core-local interruptor for the rv64 core: holds the 64-bit `mtime` counter, the `mtimecmp` compare register and the `msip` bit as memory-mapped registers behind a single-outstanding load/store port from the LSU. It produces the machine-timer pending level that the CSR block samples into `mip.MTIP` and qualifies with `mstatus.MIE` and `mie.MTIE`. It is the block directly upstream of the CSR timer-interrupt input.

---
 rtl/ysyx_22040228_clint_if.sv | 26 ++
 rtl/ysyx_22040228_clint.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ysyx_22040228_clint_if.sv
// LSU <-> CLINT load/store port: one request channel, one response channel,
// at most one transaction in flight.
interface ysyx_22040228_clint_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_err;

   // LSU side
   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   // CLINT side
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/ysyx_22040228_clint.sv
// Core-local interruptor: mtime / mtimecmp / msip behind a single-outstanding
// load/store port, plus the registered machine-timer pending level.
module ysyx_22040228_clint #(
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   ysyx_22040228_clint_if.slave       bus,
   output logic                       tmr_intr_ena,
   output logic                       msip_o
);

   typedef enum logic {IDLE, RESP} state_t;

   // Register offsets expressed as 8-byte word indices (address bits [15:3]).
   localparam logic [12:0] WORD_MSIP     = 13'h0000;
   localparam logic [12:0] WORD_MTIMECMP = 13'h0800;
   localparam logic [12:0] WORD_MTIME    = 13'h17FF;
   localparam logic [15:0] PRESC_LAST    = 16'(TICK_DIV - 1);

   state_t      state;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        msip;
   logic [15:0] presc;

   logic        accept;
   logic        store;
   logic        in_window;
   logic        sel_msip;
   logic        sel_mtimecmp;
   logic        sel_mtime;
   logic        mapped;
   logic        tick;
   logic [63:0] mtime_inc;
   logic [63:0] mtime_next;
   logic [63:0] mtimecmp_next;
   logic        msip_next;
   logic [63:0] load_data;
   logic        unused_addr_bits;

   // Replace only the bytes whose strobe is set.
   function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
      logic [63:0] res;
      res = old_val;
      for (int i = 0; i < 8; i++) begin
         if (strb[i]) begin
            res[i*8 +: 8] = new_val[i*8 +: 8];
         end
      end
      return res;
   endfunction

   // The byte offset inside a word is meaningless for 64-bit registers.
   assign unused_addr_bits = ^bus.req_addr[2:0];
   assign msip_o           = msip;

   // Address decode, tick generation and next-state values of the registers;
   // a store overrides the ticked mtime only in the bytes it writes.
   always_comb begin
      accept        = bus.req_valid && (state == IDLE);
      store         = accept && bus.req_we;
      in_window     = (bus.req_addr[63:16] == BASE_ADDR[63:16]);
      sel_msip      = in_window && (bus.req_addr[15:3] == WORD_MSIP);
      sel_mtimecmp  = in_window && (bus.req_addr[15:3] == WORD_MTIMECMP);
      sel_mtime     = in_window && (bus.req_addr[15:3] == WORD_MTIME);
      mapped        = sel_msip || sel_mtimecmp || sel_mtime;
      tick          = (presc == PRESC_LAST);
      mtime_inc     = tick ? (mtime + 64'd1) : mtime;
      mtime_next    = mtime_inc;
      mtimecmp_next = mtimecmp;
      msip_next     = msip;
      load_data     = 64'd0;
      if (store && sel_mtime) begin
         mtime_next = merge_bytes(mtime_inc, bus.req_wdata, bus.req_wstrb);
      end
      if (store && sel_mtimecmp) begin
         mtimecmp_next = merge_bytes(mtimecmp, bus.req_wdata, bus.req_wstrb);
      end
      if (store && sel_msip && bus.req_wstrb[0]) begin
         msip_next = bus.req_wdata[0];
      end
      if (!bus.req_we) begin
         if (sel_msip) begin
            load_data = {63'd0, msip};
         end else if (sel_mtimecmp) begin
            load_data = mtimecmp;
         end else if (sel_mtime) begin
            load_data = mtime;
         end
      end
   end

   // Timer, compare and software-interrupt registers plus the pending level,
   // which is compared from the values held before this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc        <= 16'd0;
         mtime        <= 64'd0;
         mtimecmp     <= 64'hFFFF_FFFF_FFFF_FFFF;
         msip         <= 1'b0;
         tmr_intr_ena <= 1'b0;
      end else begin
         presc        <= tick ? 16'd0 : (presc + 16'd1);
         mtime        <= mtime_next;
         mtimecmp     <= mtimecmp_next;
         msip         <= msip_next;
         tmr_intr_ena <= (mtime >= mtimecmp);
      end
   end

   // Request/response handshake with registered ready, valid, data and error.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= 64'd0;
         bus.rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  state         <= RESP;
                  bus.req_ready <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_rdata <= load_data;
                  bus.rsp_err   <= !mapped;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state         <= IDLE;
                  bus.req_ready <= 1'b1;
                  bus.rsp_valid <= 1'b0;
               end
            end
            default: begin
               state         <= IDLE;
               bus.req_ready <= 1'b1;
               bus.rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
